// File: rtl/morph_pkg.sv
// Shared types and helpers for the binary morphology filter.
package morph_pkg;

   // Frame-level control states.
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_RUN,
      ST_FLUSH
   } morph_state_t;

   // Reduction operator selected at start of frame.
   typedef enum logic {
      MORPH_ERODE  = 1'b0,
      MORPH_DILATE = 1'b1
   } morph_mode_t;

   // Kernel radius for a square kernel of side k.
   function automatic int morph_radius(input int k);
      return (k - 1) / 2;
   endfunction

   // Pixels that must be buffered before the first output can be formed.
   function automatic int morph_delay(input int k, input int img_w);
      return morph_radius(k) * img_w + morph_radius(k);
   endfunction

endpackage

// File: rtl/morph_linebuf.sv
// One image line of delay: an IMG_W-bit shift line with enable and clear.
module morph_linebuf #(
   parameter int IMG_W = 640
) (
   input  logic CLK,
   input  logic clr,
   input  logic en,
   input  logic din,
   output logic dout
);

   logic [IMG_W-1:0] line_reg;

   // Shift one pixel in per enabled cycle; the oldest bit is the output.
   always_ff @(posedge CLK) begin
      if (clr) begin
         line_reg <= '0;
      end else if (en) begin
         line_reg <= {line_reg[IMG_W-2:0], din};
      end
   end

   assign dout = line_reg[IMG_W-1];

endmodule

// File: rtl/morph_filter.sv
// Streaming KxK binary erosion/dilation with in-image border masking.
// The window centre lags the newest pixel by R lines plus R pixels, so the
// output stream is the input stream delayed by D accepted pixels; the last
// D outputs are produced by flushing zeros through the pipeline.
module morph_filter
   import morph_pkg::*;
#(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int K     = 3
) (
   input  logic CLK,
   input  logic RST,
   input  logic Mode,
   input  logic In_valid,
   output logic In_ready,
   input  logic Data_in,
   input  logic Sof_in,
   output logic Out_valid,
   output logic Data_out,
   output logic Sof_out,
   output logic Eof_out
);

   localparam int R  = morph_radius(K);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   morph_state_t state_reg, state_next;
   morph_mode_t  mode_reg;

   logic [CW-1:0] col_reg, ox_reg, out_x_reg;
   logic [RW-1:0] row_reg, oy_reg, out_y_reg;
   logic          out_valid_reg;
   logic [K-1:0]  win_reg [K];
   logic [K-1:0]  tap;

   logic accept, sof_acc, shift_en, out_fire, frame_start;
   logic shift_din, last_in, last_out, fill_done, red;

   assign In_ready  = !RST && (state_reg != ST_FLUSH);
   assign accept    = In_valid && In_ready;
   assign sof_acc   = accept && Sof_in;
   assign shift_din = (state_reg == ST_FLUSH) ? 1'b0 : Data_in;
   assign last_in   = (col_reg == CW'(IMG_W - 1)) && (row_reg == RW'(IMG_H - 1));
   assign last_out  = (ox_reg == CW'(IMG_W - 1)) && (oy_reg == RW'(IMG_H - 1));
   assign fill_done = (col_reg == CW'(R - 1)) && (row_reg == RW'(R));

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) state_reg <= ST_IDLE;
      else     state_reg <= state_next;
   end

   // Next state and per-cycle pipeline controls.
   always_comb begin
      state_next  = state_reg;
      shift_en    = 1'b0;
      out_fire    = 1'b0;
      frame_start = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (sof_acc) begin
               frame_start = 1'b1;
               shift_en    = 1'b1;
               state_next  = ST_FILL;
            end
         end
         ST_FILL: begin
            if (sof_acc) begin
               frame_start = 1'b1;
               shift_en    = 1'b1;
            end else if (accept) begin
               shift_en = 1'b1;
               if (fill_done) state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (sof_acc) begin
               frame_start = 1'b1;
               shift_en    = 1'b1;
               state_next  = ST_FILL;
            end else if (accept) begin
               shift_en = 1'b1;
               out_fire = 1'b1;
               if (last_in) state_next = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            shift_en = 1'b1;
            out_fire = 1'b1;
            if (last_out) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Line buffers: tap[K-1] is the newest row, tap[0] the oldest.
   assign tap[K-1] = shift_din;
   generate
      for (genvar gi = 0; gi < K - 1; gi++) begin : g_line
         morph_linebuf #(.IMG_W(IMG_W)) u_line (
            .CLK  (CLK),
            .clr  (RST),
            .en   (shift_en),
            .din  (tap[K-1-gi]),
            .dout (tap[K-2-gi])
         );
      end
   endgenerate

   // Counters, mode latch, window shift and output coordinate registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         mode_reg      <= MORPH_ERODE;
         col_reg       <= '0;
         row_reg       <= '0;
         ox_reg        <= '0;
         oy_reg        <= '0;
         out_x_reg     <= '0;
         out_y_reg     <= '0;
         out_valid_reg <= 1'b0;
         for (int r = 0; r < K; r++) win_reg[r] <= '0;
      end else begin
         out_valid_reg <= out_fire;
         if (frame_start) begin
            // The Sof pixel itself is pixel 0, so the next one is column 1.
            mode_reg <= morph_mode_t'(Mode);
            col_reg  <= CW'(1);
            row_reg  <= '0;
            ox_reg   <= '0;
            oy_reg   <= '0;
         end else if (shift_en && state_reg != ST_FLUSH) begin
            if (col_reg == CW'(IMG_W - 1)) begin
               col_reg <= '0;
               if (row_reg != RW'(IMG_H - 1)) row_reg <= row_reg + 1'b1;
            end else begin
               col_reg <= col_reg + 1'b1;
            end
         end
         if (out_fire) begin
            out_x_reg <= ox_reg;
            out_y_reg <= oy_reg;
            if (ox_reg == CW'(IMG_W - 1)) begin
               ox_reg <= '0;
               if (oy_reg != RW'(IMG_H - 1)) oy_reg <= oy_reg + 1'b1;
            end else begin
               ox_reg <= ox_reg + 1'b1;
            end
         end
         if (shift_en) begin
            for (int r = 0; r < K; r++) begin
               for (int c = 0; c < K - 1; c++) win_reg[r][c] <= win_reg[r][c+1];
               win_reg[r][K-1] <= tap[r];
            end
         end
      end
   end

   // Masked reduce: window cell (r,c) is image pixel (x+c-R, y+r-R).
   always_comb begin
      int xx, yy;
      xx  = 0;
      yy  = 0;
      red = (mode_reg == MORPH_ERODE);
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K; c++) begin
            xx = int'(out_x_reg) + c - R;
            yy = int'(out_y_reg) + r - R;
            if (xx >= 0 && xx < IMG_W && yy >= 0 && yy < IMG_H) begin
               if (mode_reg == MORPH_ERODE) red = red & win_reg[r][c];
               else                         red = red | win_reg[r][c];
            end
         end
      end
   end

   assign Out_valid = out_valid_reg;
   assign Data_out  = out_valid_reg && red;
   assign Sof_out   = out_valid_reg && (out_x_reg == '0) && (out_y_reg == '0);
   assign Eof_out   = out_valid_reg && (out_x_reg == CW'(IMG_W - 1)) &&
                      (out_y_reg == RW'(IMG_H - 1));

endmodule

// File: tb/tb_morph_filter.sv
// Randomized bench for morph_filter against a direct window-rule model.
module tb_morph_filter;
   import morph_pkg::*;

   localparam int W    = 8;
   localparam int H    = 6;
   localparam int NPIX = W * H;

   typedef struct packed {
      logic d;
      logic s;
      logic e;
   } out_t;

   logic clk, rst, in_valid, data_in, sof_in, mode_in;
   bit   sel;
   logic iv3, rdy3, ov3, do3, so3, eo3;
   logic iv5, rdy5, ov5, do5, so5, eo5;
   logic obs_rdy, obs_ov, obs_do, obs_so, obs_eo;
   morph_state_t obs_state;

   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;
   out_t exp_q[$];
   out_t got_q[$];
   int   cyc_q[$];

   assign iv3 = in_valid && !sel;
   assign iv5 = in_valid && sel;
   assign obs_rdy   = sel ? rdy5 : rdy3;
   assign obs_ov    = sel ? ov5  : ov3;
   assign obs_do    = sel ? do5  : do3;
   assign obs_so    = sel ? so5  : so3;
   assign obs_eo    = sel ? eo5  : eo3;
   assign obs_state = sel ? u_dut5.state_reg : u_dut3.state_reg;

   morph_filter #(.IMG_W(W), .IMG_H(H), .K(3)) u_dut3 (
      .CLK(clk), .RST(rst), .Mode(mode_in), .In_valid(iv3), .In_ready(rdy3),
      .Data_in(data_in), .Sof_in(sof_in), .Out_valid(ov3), .Data_out(do3),
      .Sof_out(so3), .Eof_out(eo3)
   );

   morph_filter #(.IMG_W(W), .IMG_H(H), .K(5)) u_dut5 (
      .CLK(clk), .RST(rst), .Mode(mode_in), .In_valid(iv5), .In_ready(rdy5),
      .Data_in(data_in), .Sof_in(sof_in), .Out_valid(ov5), .Data_out(do5),
      .Sof_out(so5), .Eof_out(eo5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Collect every output beat of the selected instance.
   always @(negedge clk) begin
      if (obs_ov === 1'b1) begin
         got_q.push_back('{d: obs_do, s: obs_so, e: obs_eo});
         cyc_q.push_back(cyc);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   task automatic check_val(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Reference: reduce over the in-image part of the KxK neighbourhood.
   function automatic logic golden(input logic [NPIX-1:0] fr, input logic md,
                                   input int k, input int x, input int y);
      int   r;
      logic acc;
      r   = (k - 1) / 2;
      acc = !md;
      for (int dy = -r; dy <= r; dy++)
         for (int dx = -r; dx <= r; dx++)
            if (x + dx >= 0 && x + dx < W && y + dy >= 0 && y + dy < H) begin
               if (md) acc = acc | fr[(y + dy) * W + x + dx];
               else    acc = acc & fr[(y + dy) * W + x + dx];
            end
      return acc;
   endfunction

   function automatic int cur_k();
      return sel ? 5 : 3;
   endfunction

   function automatic int cur_d();
      return ((cur_k() - 1) / 2) * W + (cur_k() - 1) / 2;
   endfunction

   task automatic add_exp(input logic [NPIX-1:0] fr, input logic md, input int n);
      for (int i = 0; i < n; i++)
         exp_q.push_back('{d: golden(fr, md, cur_k(), i % W, i / W),
                           s: (i == 0), e: (i == NPIX - 1)});
   endtask

   task automatic clear_q();
      exp_q.delete();
      got_q.delete();
      cyc_q.delete();
   endtask

   // Offer npix pixels of fr, optionally with random idle cycles.
   task automatic drive(input logic [NPIX-1:0] fr, input logic md, input int npix,
                        input bit gaps);
      int idx, guard;
      idx   = 0;
      guard = 0;
      while (idx < npix && guard < 5000) begin
         @(negedge clk);
         guard++;
         if (gaps && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            sof_in   = 1'b0;
            mode_in  = 1'($urandom_range(0, 1));
         end else begin
            in_valid = 1'b1;
            data_in  = fr[idx];
            sof_in   = (idx == 0);
            mode_in  = (idx == 0) ? md : 1'($urandom_range(0, 1));
         end
         if (in_valid && obs_rdy) idx++;
      end
      check_val("drive_accepted", idx, npix);
   endtask

   // Non-Sof pixels offered in IDLE must be dropped.
   task automatic send_junk();
      repeat (3) begin
         @(negedge clk);
         in_valid = 1'b1;
         sof_in   = 1'b0;
         data_in  = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic finish_frame();
      int lowcnt;
      lowcnt = 0;
      @(negedge clk);
      in_valid = 1'b0;
      sof_in   = 1'b0;
      while (!obs_rdy && lowcnt < 200) begin
         lowcnt++;
         @(negedge clk);
      end
      check_val("flush_ready_low", lowcnt, cur_d());
      check_val("fsm_idle", int'(obs_state), int'(ST_IDLE));
      repeat (3) @(negedge clk);
   endtask

   task automatic compare(input bit contig);
      int n;
      check_val("out_count", got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check_val($sformatf("out%0d_dse", i), int'(got_q[i]), int'(exp_q[i]));
      if (contig && cyc_q.size() > 0)
         check_val("contiguous", cyc_q[cyc_q.size() - 1] - cyc_q[0], NPIX - 1);
   endtask

   function automatic int ones_got();
      int n;
      n = 0;
      foreach (got_q[i]) n += int'(got_q[i].d);
      return n;
   endfunction

   task automatic run_frame(input logic [NPIX-1:0] fr, input logic md,
                            input bit gaps, input bit junk);
      clear_q();
      add_exp(fr, md, NPIX);
      if (junk) send_junk();
      drive(fr, md, NPIX, gaps);
      finish_frame();
      compare(!gaps);
   endtask

   function automatic logic [NPIX-1:0] rand_frame(input logic md);
      logic [63:0] a, b, c;
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      c = {$urandom(), $urandom()};
      return md ? NPIX'(a & b & c) : NPIX'(a | b | c);
   endfunction

   initial begin
      logic [NPIX-1:0] fa, fb, single;
      logic ma, mb;
      rst = 1'b1; in_valid = 1'b0; data_in = 1'b0; sof_in = 1'b0;
      mode_in = 1'b0; sel = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_ready3", int'(rdy3), 0);
      check_val("rst_ready5", int'(rdy5), 0);
      check_val("rst_valid", int'(ov3), 0);
      check_val("rst_data", int'(do3), 0);
      check_val("rst_sof_eof", int'({so3, eo3}), 0);
      rst = 1'b0;
      @(negedge clk);
      check_val("post_rst_ready", int'(rdy3), 1);

      // All-ones erosion, back-to-back pixels.
      run_frame({NPIX{1'b1}}, 1'b0, 1'b0, 1'b0);
      check_val("allones_ones", ones_got(), NPIX);

      // Single set pixel at (3,2): dilation gives a 3x3 block, erosion nothing.
      single = '0;
      single[2 * W + 3] = 1'b1;
      run_frame(single, 1'b1, 1'b0, 1'b0);
      check_val("single_dilate_ones", ones_got(), 9);
      run_frame(single, 1'b0, 1'b1, 1'b0);
      check_val("single_erode_ones", ones_got(), 0);

      // Random frames, random gaps, junk pixels in IDLE.
      for (int t = 0; t < 6; t++) begin
         ma = 1'($urandom_range(0, 1));
         run_frame(rand_frame(ma), ma, (t % 2) == 0, (t % 3) == 0);
      end

      // Abort: Sof reasserted on the 20th pixel.
      ma = 1'b1; mb = 1'b0;
      fa = rand_frame(ma);
      fb = rand_frame(mb);
      clear_q();
      add_exp(fa, ma, 19 - cur_d());
      add_exp(fb, mb, NPIX);
      drive(fa, ma, 19, 1'b1);
      drive(fb, mb, NPIX, 1'b1);
      finish_frame();
      compare(1'b0);

      // One-cycle reset in RUN, then a clean frame.
      drive(rand_frame(1'b0), 1'b0, 25, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      sof_in   = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      check_val("midrst_valid", int'(obs_ov), 0);
      check_val("midrst_data", int'(obs_do), 0);
      check_val("midrst_sof_eof", int'({obs_so, obs_eo}), 0);
      check_val("midrst_ready", int'(obs_rdy), 0);
      check_val("midrst_idle", int'(obs_state), int'(ST_IDLE));
      rst = 1'b0;
      @(negedge clk);
      check_val("midrst_ready_after", int'(obs_rdy), 1);
      ma = 1'($urandom_range(0, 1));
      run_frame(rand_frame(ma), ma, 1'b1, 1'b0);

      // K=5 instance: all ones except (0,0), erosion.
      sel = 1'b1;
      @(negedge clk);
      fa = {NPIX{1'b1}};
      fa[0] = 1'b0;
      run_frame(fa, 1'b0, 1'b0, 1'b0);
      check_val("k5_zeros", NPIX - ones_got(), 9);
      ma = 1'($urandom_range(0, 1));
      run_frame(rand_frame(ma), ma, 1'b1, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
